bitonic_sort_ctrl: RTL and testbench
====================================

# bitonic_sort_ctrl

Sequential 8-entry bitonic sorter controller. It collects eight numbers over a valid/ready stream and runs the full 8-point bitonic network as six compare-exchange passes, one pass per clock, on a shared bank of four compare-exchange units. It then streams the sorted numbers back out. It sits between an input stream and its consumer, and replaces the fully unrolled combinational sorter stages when area matters more than latency.

## Interface
- WIDTH, 8, bit width of each number (unsigned).
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  producer has a number on in_data.
- in_data  input  WIDTH  number to load.
- in_ready  output  1  block accepts a number this cycle.
- out_valid  output  1  sorted number on out_data.
- out_data  output  WIDTH  sorted number.
- out_last  output  1  marks the 8th (final) output beat.
- out_ready  input  1  consumer accepts out_data.
- busy  output  1  high in SORT and DRAIN.

## Operation
- Storage: eight WIDTH-bit registers r[0..7]. Load pointer idx[2:0]. Pass counter pass[2:0].
- The FSM has four states: IDLE, LOAD, SORT, DRAIN. Transitions:
  - IDLE → LOAD on the first input handshake; that beat is written to r[0].
  - LOAD writes r[idx] on each handshake. After the handshake with idx=7, the FSM goes to SORT with pass=0.
  - SORT → DRAIN after pass 5 completes.
  - DRAIN → IDLE after the output handshake with idx=7.
- Input handshake: in_valid && in_ready. in_ready=1 only in IDLE/LOAD.
- Output handshake: out_valid && out_ready. out_valid=1 only in DRAIN. out_data=r[idx].
- Pass table (k, j) for pass 0..5: (2,1), (4,2), (4,1), (8,4), (8,2), (8,1).
  - For each i with (i & j)==0, compare r[i] with r[i^j].
  - The pair is ascending (smaller to r[i]) if (i & k)==0, descending otherwise.
  - All four pairs update in the same cycle.
- Equal values are not swapped. Comparison is unsigned.
- Default final order is ascending: r[0] is smallest, and r[0] is output first.
- idx resets to 0 on every state entry that uses it (LOAD from IDLE, DRAIN).
- No overlap: new input is not accepted until the drain completes.

## Timing
- Reset (async assert, sync release): state=IDLE, in_ready=0, out_valid=0, out_last=0, busy=0, out_data=0, r[*]=0, idx=0, pass=0.
- in_ready is registered. It rises on the first clk edge after rst_n deasserts, and on the edge that enters IDLE.
- Let the 8th input handshake happen at edge t. Passes execute at edges t+1 … t+6. out_valid=1 from edge t+6. Sort latency is therefore 6 cycles.
- In DRAIN, out_data/out_last are held stable while out_valid && !out_ready.
- out_last=1 exactly while idx=7 in DRAIN.
- The final output handshake at edge u gives out_valid=0 and busy=0 after u, and in_ready=1 after u.
- Best-case throughput: one sort per 8+6+8 = 22 cycles.
- In SORT and DRAIN, in_valid is ignored; no beat is accepted or dropped silently, because in_ready=0.
- If rst_n asserts mid-LOAD/SORT/DRAIN, the in-progress set is discarded and all outputs immediately take their reset values.

## Configuration
- BITONIC_DESCEND_EN is defined: every pair direction is inverted, so the final order is descending and the largest value is output first.
- BITONIC_DESCEND_EN is undefined: the final order is ascending.
- Handshake and timing are identical in both builds.

## Structure
- Package bitonic_pkg holds:
  - N_ELEM=8 and N_PASS=6.
  - The state enum (IDLE, LOAD, SORT, DRAIN).
  - The constant pass table of (k, j) values, used as log2 encodings.
- Sub-module bitonic_cmp_swap (WIDTH parameter) takes a, b and a dir input, and outputs lo/hi ordered per dir. It is instantiated four times.
- The controller computes pair indices and dir from the pass table.

## Test plan
- Reset, then load 8,7,6,5,4,3,2,1 with out_ready=1 → out_valid rises 6 cycles after the 8th load. Output is 1..8 over 8 consecutive cycles; out_last is set on the 8. Under BITONIC_DESCEND_EN the output is 8..1.
- Load 5,5,0,255,5,0,255,1 → output 0,0,1,5,5,5,255,255. Duplicates and extremes are preserved.
- Apply in_valid with gaps (every other cycle) during LOAD, and toggle out_ready 1,0,0,1 during DRAIN → no lost or duplicated beats. out_data/out_last are held across stalls.
- Hold in_valid=1 continuously from the 8th beat through DRAIN → in_ready=0 throughout SORT/DRAIN, and the 9th value is accepted only after the final output handshake.
- Assert rst_n low during pass 3 of SORT → all outputs are 0 asynchronously. After release, load 3,1,2,0,7,6,5,4 → output 0..7 with no residue from the aborted set.
- Run 100 random 8-number sets with random valid/ready stalls → output matches the reference sort every time, and busy matches SORT/DRAIN occupancy.

Source files
------------

// File: rtl/bitonic_pkg.sv
// Shared types and constants for the sequential 8-entry bitonic sorter.
// The pass table is stored as log2 encodings of the (k, j) network parameters.
package bitonic_pkg;

  localparam int unsigned N_ELEM = 8;
  localparam int unsigned N_PASS = 6;
  localparam int unsigned N_CMP  = N_ELEM / 2;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned LOG_W  = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SORT  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  typedef struct packed {
    logic [LOG_W-1:0] k_log2;
    logic [LOG_W-1:0] j_log2;
  } pass_t;

  // (k, j) per pass: (2,1) (4,2) (4,1) (8,4) (8,2) (8,1)
  function automatic pass_t pass_lookup(input logic [IDX_W-1:0] p);
    pass_t t;
    case (p)
      3'd0:    t = '{k_log2: 2'd1, j_log2: 2'd0};
      3'd1:    t = '{k_log2: 2'd2, j_log2: 2'd1};
      3'd2:    t = '{k_log2: 2'd2, j_log2: 2'd0};
      3'd3:    t = '{k_log2: 2'd3, j_log2: 2'd2};
      3'd4:    t = '{k_log2: 2'd3, j_log2: 2'd1};
      default: t = '{k_log2: 2'd3, j_log2: 2'd0};
    endcase
    return t;
  endfunction

  // u-th index i with bit j clear: insert a zero at bit position log2(j)
  function automatic logic [IDX_W-1:0] pair_base(input logic [1:0] u,
                                                 input logic [LOG_W-1:0] j_log2);
    logic [IDX_W-1:0] i;
    case (j_log2)
      2'd0:    i = {u, 1'b0};
      2'd1:    i = {u[1], 1'b0, u[0]};
      default: i = {1'b0, u};
    endcase
    return i;
  endfunction

  // A pair is descending when (i & k) != 0; k = 8 never hits a 3-bit index
  function automatic logic pair_desc(input logic [IDX_W-1:0] i,
                                     input logic [LOG_W-1:0] k_log2);
    logic d;
    case (k_log2)
      2'd1:    d = i[1];
      2'd2:    d = i[2];
      default: d = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/bitonic_cmp_swap.sv
// One compare-exchange unit: lo lands at the lower index, hi at the upper.
// dir=0 orders ascending, dir=1 descending; equal values pass through unswapped.
module bitonic_cmp_swap #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             dir,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  logic swap_c;

  assign swap_c = dir ? (a < b) : (a > b);
  assign lo     = swap_c ? b : a;
  assign hi     = swap_c ? a : b;

endmodule

// File: rtl/bitonic_sort_ctrl.sv
// Sequential 8-entry bitonic sorter: load 8 beats, run 6 passes on 4 shared
// compare-exchange units, stream results out. BITONIC_DESCEND_EN flips order.
module bitonic_sort_ctrl
  import bitonic_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic             busy
);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] pass;
  logic [WIDTH-1:0] r     [N_ELEM];
  logic [WIDTH-1:0] r_nxt [N_ELEM];

  logic             in_hs, out_hs, last_idx, last_pass;
  pass_t            cur_pass;
  logic [IDX_W-1:0] pa [N_CMP];
  logic [IDX_W-1:0] pb [N_CMP];
  logic [N_CMP-1:0] dir;
  logic [WIDTH-1:0] lo [N_CMP];
  logic [WIDTH-1:0] hi [N_CMP];

  logic             in_ready_nxt, out_valid_nxt, out_last_nxt, busy_nxt;
  logic [WIDTH-1:0] out_data_nxt;

  assign in_hs     = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;
  assign last_idx  = (idx == IDX_W'(N_ELEM - 1));
  assign last_pass = (pass == IDX_W'(N_PASS - 1));
  assign cur_pass  = pass_lookup(pass);

  // Pair indices and directions for the current pass
  always_comb begin
    for (int u = 0; u < N_CMP; u++) begin
      pa[u] = pair_base(2'(u), cur_pass.j_log2);
      pb[u] = pa[u] ^ (IDX_W'(1) << cur_pass.j_log2);
`ifdef BITONIC_DESCEND_EN
      dir[u] = ~pair_desc(pa[u], cur_pass.k_log2);
`else
      dir[u] = pair_desc(pa[u], cur_pass.k_log2);
`endif
    end
  end

  for (genvar u = 0; u < N_CMP; u++) begin : g_cmp
    bitonic_cmp_swap #(.WIDTH(WIDTH)) u_cmp (
      .a   (r[pa[u]]),
      .b   (r[pb[u]]),
      .dir (dir[u]),
      .lo  (lo[u]),
      .hi  (hi[u])
    );
  end

  // Register bank after applying the current pass
  always_comb begin
    for (int e = 0; e < N_ELEM; e++) r_nxt[e] = r[e];
    for (int u = 0; u < N_CMP; u++) begin
      r_nxt[pa[u]] = lo[u];
      r_nxt[pb[u]] = hi[u];
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_hs) state_nxt = LOAD;
      LOAD:    if (in_hs && last_idx) state_nxt = SORT;
      SORT:    if (last_pass) state_nxt = DRAIN;
      DRAIN:   if (out_hs && last_idx) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs
  always_comb begin
    in_ready_nxt  = (state_nxt == IDLE) || (state_nxt == LOAD);
    out_valid_nxt = (state_nxt == DRAIN);
    busy_nxt      = (state_nxt == SORT) || (state_nxt == DRAIN);
    out_last_nxt  = 1'b0;
    out_data_nxt  = out_data;
    case (state)
      SORT: if (last_pass) out_data_nxt = r_nxt[0];
      DRAIN: begin
        if (out_hs) begin
          if (!last_idx) begin
            out_data_nxt = r[idx + IDX_W'(1)];
            out_last_nxt = (idx == IDX_W'(N_ELEM - 2));
          end
        end else begin
          out_last_nxt = out_last;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      out_data  <= '0;
    end else begin
      in_ready  <= in_ready_nxt;
      out_valid <= out_valid_nxt;
      out_last  <= out_last_nxt;
      busy      <= busy_nxt;
      out_data  <= out_data_nxt;
    end
  end

  // Datapath: load pointer, pass counter and storage bank
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx  <= '0;
      pass <= '0;
      for (int e = 0; e < N_ELEM; e++) r[e] <= '0;
    end else begin
      case (state)
        IDLE, LOAD: begin
          pass <= '0;
          if (in_hs) begin
            r[idx] <= in_data;
            idx    <= idx + IDX_W'(1);
          end
        end
        SORT: begin
          for (int e = 0; e < N_ELEM; e++) r[e] <= r_nxt[e];
          pass <= last_pass ? '0 : pass + IDX_W'(1);
          idx  <= '0;
        end
        DRAIN: if (out_hs) idx <= idx + IDX_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bitonic_sort_ctrl.sv
// Scoreboard bench for bitonic_sort_ctrl: driver pushes expected sorted beats,
// an independent monitor pops and compares on every output handshake.
module tb_bitonic_sort_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;
  logic       out_ready = 1'b1;
  logic       busy;

  always #5 clk = ~clk;

  bitonic_sort_ctrl #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .busy      (busy)
  );

  int         n_checks = 0;
  int         n_pass   = 0;
  int         cyc      = 0;
  logic [7:0] exp_q[$];
  bit         occ      = 1'b0;
  bit         clr_occ  = 1'b0;
  int         t_load   = 0;
  int         last_hs_edge = 0;
  int         rdy_mode = 0;
  int         ph       = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push_expected(input logic [7:0] e [8]);
`ifdef BITONIC_DESCEND_EN
    for (int i = 7; i >= 0; i--) exp_q.push_back(e[i]);
`else
    for (int i = 0; i < 8; i++) exp_q.push_back(e[i]);
`endif
  endtask

  task automatic sort8(input logic [7:0] v [8], output logic [7:0] s [8]);
    logic [7:0] t;
    s = v;
    for (int i = 1; i < 8; i++)
      for (int j = i; j > 0; j--)
        if (s[j-1] > s[j]) begin t = s[j]; s[j] = s[j-1]; s[j-1] = t; end
  endtask

  task automatic drive_beat(input logic [7:0] val, output int edge_no);
    int n;
    n = 0;
    edge_no = -1;
    in_valid = 1'b1;
    in_data  = val;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 300) begin
        n_checks++;
        $display("FAIL in_handshake_timeout: no in_ready after %0d cycles, required within 300", n);
        return;
      end
    end
    @(posedge clk);
    #1;
    edge_no = cyc;
  endtask

  // gap < 0 selects a random 0..2 cycle gap after each beat
  task automatic send_set(input logic [7:0] v [8], input logic [7:0] e [8], input int gap,
                          input bit hold, input logic [7:0] nxt, output int first_edge);
    int ed, g;
    first_edge = -1;
    for (int b = 0; b < 8; b++) begin
      drive_beat(v[b], ed);
      if (b == 0) first_edge = ed;
      if (b < 7) begin
        g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
        if (g > 0) begin
          in_valid = 1'b0;
          repeat (g) @(posedge clk);
          #1;
        end
      end
    end
    t_load = cyc;
    occ = 1'b1;
    push_expected(e);
    if (hold) begin in_valid = 1'b1; in_data = nxt; end
    else in_valid = 1'b0;
  endtask

  task automatic wait_drained();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || occ) && n < 500) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (n >= 500) begin
      n_checks++;
      $display("FAIL drain_timeout: %0d beats still pending, required 0", exp_q.size());
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (clr_occ) begin occ = 1'b0; clr_occ = 1'b0; end
    case (rdy_mode)
      1: begin out_ready = (ph % 4 == 0) || (ph % 4 == 3); ph++; end
      2: out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b1;
    endcase
  end

  // Monitor: scoreboard pop, stall hold, latency, busy and in_ready occupancy
  int         beat = 0;
  bit         held_v = 1'b0;
  logic [7:0] held_data;
  logic       held_last;
  logic       prev_ov = 1'b0;
  logic [7:0] exp_d;

  always @(negedge clk) begin
    if (!rst_n) begin
      held_v  = 1'b0;
      prev_ov = 1'b0;
      beat    = 0;
    end else begin
      check("busy", int'(busy), int'(occ));
      if (occ) check("in_ready_while_busy", int'(in_ready), 0);
      if (out_valid && !prev_ov) check("sort_latency", cyc - t_load, 6);
      if (held_v && out_valid) begin
        check("stall_hold_data", int'(out_data), int'(held_data));
        check("stall_hold_last", int'(out_last), int'(held_last));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_output: got %0d, required no beat", out_data);
        end else begin
          exp_d = exp_q.pop_front();
          check("out_data", int'(out_data), int'(exp_d));
          check("out_last", int'(out_last), int'(beat == 7));
        end
        if (beat == 7) begin
          beat = 0;
          last_hs_edge = cyc + 1;
          clr_occ = 1'b1;
        end else begin
          beat++;
        end
      end
      held_v    = out_valid && !out_ready;
      held_data = out_data;
      held_last = out_last;
      prev_ov   = out_valid;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation still running, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] vin [8];
    logic [7:0] vexp [8];
    int fe;

    #1;
    check("reset_in_ready", int'(in_ready), 0);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_out_last", int'(out_last), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_out_data", int'(out_data), 0);
    #21 rst_n = 1'b1;
    #1 check("in_ready_before_edge", int'(in_ready), 0);
    @(posedge clk); #1;
    check("in_ready_after_release", int'(in_ready), 1);

    // Reverse order input
    rdy_mode = 0;
    vin  = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    vexp = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    send_set(vin, vexp, 0, 1'b0, 8'd0, fe);
    wait_drained();

    // Duplicates and extremes
    vin  = '{8'd5, 8'd5, 8'd0, 8'd255, 8'd5, 8'd0, 8'd255, 8'd1};
    vexp = '{8'd0, 8'd0, 8'd1, 8'd5, 8'd5, 8'd5, 8'd255, 8'd255};
    send_set(vin, vexp, 0, 1'b0, 8'd0, fe);
    wait_drained();

    // Input gaps and 1,0,0,1 output stalls
    rdy_mode = 1;
    ph = 0;
    vin  = '{8'd200, 8'd17, 8'd99, 8'd3, 8'd250, 8'd17, 8'd64, 8'd128};
    vexp = '{8'd3, 8'd17, 8'd17, 8'd64, 8'd99, 8'd128, 8'd200, 8'd250};
    send_set(vin, vexp, 1, 1'b0, 8'd0, fe);
    wait_drained();

    // in_valid held through SORT/DRAIN: next set starts one edge after final output
    rdy_mode = 0;
    vin  = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80};
    vexp = vin;
    send_set(vin, vexp, 0, 1'b1, 8'd9, fe);
    vin  = '{8'd9, 8'd1, 8'd8, 8'd2, 8'd7, 8'd3, 8'd6, 8'd4};
    vexp = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd6, 8'd7, 8'd8, 8'd9};
    send_set(vin, vexp, 0, 1'b0, 8'd0, fe);
    check("ninth_beat_edge", fe, last_hs_edge + 1);
    wait_drained();

    // Asynchronous reset while pass 3 is pending
    vin  = '{8'd77, 8'd66, 8'd55, 8'd44, 8'd33, 8'd22, 8'd11, 8'd99};
    vexp = '{8'd11, 8'd22, 8'd33, 8'd44, 8'd55, 8'd66, 8'd77, 8'd99};
    send_set(vin, vexp, 0, 1'b0, 8'd0, fe);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("abort_in_ready", int'(in_ready), 0);
    check("abort_out_valid", int'(out_valid), 0);
    check("abort_out_last", int'(out_last), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_out_data", int'(out_data), 0);
    exp_q.delete();
    occ = 1'b0;
    clr_occ = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    vin  = '{8'd3, 8'd1, 8'd2, 8'd0, 8'd7, 8'd6, 8'd5, 8'd4};
    vexp = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
    send_set(vin, vexp, 0, 1'b0, 8'd0, fe);
    wait_drained();

    // Random sets with random input gaps and output stalls, back to back
    rdy_mode = 2;
    for (int s = 0; s < 100; s++) begin
      for (int i = 0; i < 8; i++) vin[i] = 8'($urandom_range(0, 255));
      sort8(vin, vexp);
      send_set(vin, vexp, -1, 1'b0, 8'd0, fe);
    end
    wait_drained();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
